// File: rtl/cic_decimator.sv
// -----------------------------------------------------------------------------
// cic_decimator
//
// CIC decimation filter with N integrator stages, N comb stages and a
// run-time decimation factor R of 1, 2, 4, 8 or 16. It takes one signed
// sample per valid_in cycle. The comb output is normalised by the DC gain
// (R*Q)^N, which is always a power of two, using round-half-up. The result is
// then saturated back to the input sample format.
//
// Ports
//   clk         rising-edge clock for all state
//   rst         synchronous, active-high reset
//   valid_in    cic_in carries a sample this cycle
//   dec_factor  decimation factor R (1, 2, 4, 8, 16; anything else acts as 1)
//   cic_in      signed input sample, DATA_WIDTH bits, DATA_FRAC fractional
//   cic_out     decimated, normalised output; holds between strobes
//   valid_out   one-cycle strobe per decimated sample
//   overflow    positive saturation on this output (valid_out cycle only)
//   underflow   negative saturation on this output (valid_out cycle only)
//
// Latency from the valid_in cycle of a decimation-point sample to valid_out
// is 2N+1 cycles: N integrator registers, N comb registers and one output
// register.
// -----------------------------------------------------------------------------
module cic_decimator #(
  parameter  int DATA_WIDTH = 16,
  parameter  int DATA_FRAC  = 15,
  parameter  int Q          = 1,
  parameter  int N          = 1,
  localparam int MAX_DEC    = 16,
  localparam int DEC_WIDTH  = $clog2(MAX_DEC)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [DEC_WIDTH:0]           dec_factor,
  input  logic signed [DATA_WIDTH-1:0] cic_in,
  output logic signed [DATA_WIDTH-1:0] cic_out,
  output logic                         valid_out,
  output logic                         overflow,
  output logic                         underflow
);

  // The accumulators are sized for the largest possible gain, (MAX_DEC*Q)^N.
  // Smaller R values simply leave headroom unused.
  localparam int ACC_W = DATA_WIDTH + N * $clog2(MAX_DEC * Q);
  // The rounding adder gets one guard bit, so adding 2^(S-1) to a full-scale
  // comb output cannot wrap.
  localparam int RW    = ACC_W + 1;
  localparam int LOG2Q = (Q == 2) ? 1 : 0;

  localparam logic signed [RW-1:0] SAT_MAX = RW'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

  // Input and output share one Q-format, so the fractional width never moves
  // the binary point inside the filter. The format only has to keep a sign
  // bit, and the stage count and differential delay must be in their
  // supported ranges.
  if (DATA_FRAC >= DATA_WIDTH || N < 1 || N > 4 || (Q != 1 && Q != 2)) begin : g_unsupported_params
  end

  // ---------------------------------------------------------------------------
  // Decimation factor decode
  // ---------------------------------------------------------------------------
  logic [2:0]           w_log2r;
  logic [DEC_WIDTH-1:0] w_rm1;
  logic [4:0]           w_shift;

  always_comb begin
    w_log2r = 3'd0;
    case (dec_factor)
      5'd2:    w_log2r = 3'd1;
      5'd4:    w_log2r = 3'd2;
      5'd8:    w_log2r = 3'd3;
      5'd16:   w_log2r = 3'd4;
      default: w_log2r = 3'd0;  // 1 and every illegal code behave as R = 1
    endcase
    w_rm1   = DEC_WIDTH'((5'd1 << w_log2r) - 5'd1);
    // Normalisation shift S = N * log2(R*Q). This is at most 20, so it fits
    // in 5 bits.
    w_shift = 5'(N * (int'(w_log2r) + LOG2Q));
  end

  // ---------------------------------------------------------------------------
  // Decimation counter: the sample that arrives while the count is R-1 is
  // tagged as the decimation point. The tag then travels with that sample.
  // ---------------------------------------------------------------------------
  logic [DEC_WIDTH-1:0] r_cnt;
  logic                 w_dec_point;

  assign w_dec_point = valid_in && (r_cnt == w_rm1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (valid_in) begin
      r_cnt <= w_dec_point ? '0 : r_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Integrator chain. Index 0 of each bus is the chain input, and stage gi
  // drives index gi+1. Each stage registers the valid and tag bits alongside
  // its accumulator, so a sample's tag stays aligned with it.
  // ---------------------------------------------------------------------------
  logic [N:0][ACC_W-1:0] w_ix;
  logic [N:0]            w_iv;
  logic [N:0]            w_it;

  assign w_ix[0] = {{(ACC_W - DATA_WIDTH){cic_in[DATA_WIDTH-1]}}, cic_in};
  assign w_iv[0] = valid_in;
  assign w_it[0] = w_dec_point;

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_int
    logic [ACC_W-1:0] r_acc;
    logic             r_vld;
    logic             r_tag;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_acc <= '0;
        r_vld <= 1'b0;
        r_tag <= 1'b0;
      end else begin
        r_vld <= w_iv[gi];
        r_tag <= w_iv[gi] & w_it[gi];
        // Modular wrap-around is harmless. The combs difference the values
        // and recover the exact result as long as that result fits in ACC_W.
        if (w_iv[gi]) begin
          r_acc <= r_acc + w_ix[gi];
        end
      end
    end

    assign w_ix[gi+1] = r_acc;
    assign w_iv[gi+1] = r_vld;
    assign w_it[gi+1] = r_tag;
  end

  // ---------------------------------------------------------------------------
  // Comb chain, running at the decimated rate. Only tagged samples enter it.
  // Each stage subtracts the value it saw Q decimated samples earlier.
  // ---------------------------------------------------------------------------
  logic [N:0][ACC_W-1:0] w_cx;
  logic [N:0]            w_cv;

  assign w_cx[0] = w_ix[N];
  assign w_cv[0] = w_iv[N] & w_it[N];

  for (gi = 0; gi < N; gi++) begin : g_comb
    logic [ACC_W-1:0] r_diff;
    logic [ACC_W-1:0] r_dly [Q];
    logic             r_vld;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_diff <= '0;
        r_vld  <= 1'b0;
        for (int k = 0; k < Q; k++) begin
          r_dly[k] <= '0;
        end
      end else begin
        r_vld <= w_cv[gi];
        if (w_cv[gi]) begin
          r_diff   <= w_cx[gi] - r_dly[Q-1];
          r_dly[0] <= w_cx[gi];
          for (int k = 1; k < Q; k++) begin
            r_dly[k] <= r_dly[k-1];
          end
        end
      end
    end

    assign w_cx[gi+1] = r_diff;
    assign w_cv[gi+1] = r_vld;
  end

  // ---------------------------------------------------------------------------
  // Gain normalisation: (comb + 2^(S-1)) >>> S, or a plain pass-through
  // when S = 0.
  // ---------------------------------------------------------------------------
  logic signed [RW-1:0] w_rnd_sum;
  logic signed [RW-1:0] w_rnd_shr;

  always_comb begin
    w_rnd_sum = {w_cx[N][ACC_W-1], w_cx[N]};
    if (w_shift != 5'd0) begin
      w_rnd_sum = w_rnd_sum + (RW'(1) << (w_shift - 5'd1));
    end
    w_rnd_shr = w_rnd_sum >>> w_shift;
  end

  // ---------------------------------------------------------------------------
  // Saturation to the output word
  // ---------------------------------------------------------------------------
  logic                  w_sat_hi;
  logic                  w_sat_lo;
  logic [DATA_WIDTH-1:0] w_sat_val;

  always_comb begin
    w_sat_hi  = 1'b0;
    w_sat_lo  = 1'b0;
    w_sat_val = w_rnd_shr[DATA_WIDTH-1:0];
    if (w_rnd_shr > SAT_MAX) begin
      w_sat_hi  = 1'b1;
      w_sat_val = SAT_MAX[DATA_WIDTH-1:0];
    end else if (w_rnd_shr < SAT_MIN) begin
      w_sat_lo  = 1'b1;
      w_sat_val = SAT_MIN[DATA_WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Output register. The data word holds between strobes. The flags are
  // qualified by the strobe, so they read 0 in every other cycle.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_cic_out;
  logic                  r_valid_out;
  logic                  r_overflow;
  logic                  r_underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cic_out   <= '0;
      r_valid_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_valid_out <= w_cv[N];
      r_overflow  <= w_cv[N] & w_sat_hi;
      r_underflow <= w_cv[N] & w_sat_lo;
      if (w_cv[N]) begin
        r_cic_out <= w_sat_val;
      end
    end
  end

  assign cic_out   = r_cic_out;
  assign valid_out = r_valid_out;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_cic_decimator.sv
// -----------------------------------------------------------------------------
// tb_cic_decimator
//
// Two filters share one stimulus: A uses N=1, Q=1 and B uses N=3, Q=2. Every
// decimation point is predicted from the input history. The model convolves
// the samples with the CIC impulse response, the N-fold self-convolution of
// an R*Q-long boxcar, and then rounds, shifts and saturates. Each prediction
// carries the cycle on which its strobe is due. Hand-computed vector tables
// and directed sequences cover the corner cases.
// -----------------------------------------------------------------------------
module tb_cic_decimator;

  localparam int DW = 16;
  localparam int NA = 1;
  localparam int QA = 1;
  localparam int NB = 3;
  localparam int QB = 2;
  localparam int DRAIN = 2 * NB + 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 valid_in;
  logic [4:0]           dec_factor;
  logic signed [DW-1:0] cic_in;
  logic signed [DW-1:0] out_a, out_b;
  logic                 vo_a, vo_b, ov_a, ov_b, un_a, un_b;

  always #5 clk = ~clk;

  cic_decimator #(.DATA_WIDTH(DW), .DATA_FRAC(15), .Q(QA), .N(NA)) u_dut_a (
    .clk(clk), .rst(rst), .valid_in(valid_in), .dec_factor(dec_factor),
    .cic_in(cic_in), .cic_out(out_a), .valid_out(vo_a),
    .overflow(ov_a), .underflow(un_a)
  );

  cic_decimator #(.DATA_WIDTH(DW), .DATA_FRAC(15), .Q(QB), .N(NB)) u_dut_b (
    .clk(clk), .rst(rst), .valid_in(valid_in), .dec_factor(dec_factor),
    .cic_in(cic_in), .cic_out(out_b), .valid_out(vo_b),
    .overflow(ov_b), .underflow(un_b)
  );

  typedef struct {
    int val;
    bit ovf;
    bit udf;
    int due;
  } exp_t;

  typedef struct {
    logic [4:0] dec;
    int         n_in;
    int         first;
    int         rest;
    int         exp_a;
  } vec_t;

  exp_t exp_q[2][$];
  int   hist[$];
  int   cnt = 0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   nflags = 0;
  int   hold[2];
  int   nstrobe[2];
  int   last_out[2];

  function automatic int reff(logic [4:0] d);
    case (d)
      5'd2:    return 2;
      5'd4:    return 4;
      5'd8:    return 8;
      5'd16:   return 16;
      default: return 1;
    endcase
  endfunction

  // Prediction for the decimation point that ends at the newest sample.
  function automatic exp_t model(int r, int n, int q, int due);
    longint h[$];
    longint t[$];
    longint acc;
    int     len;
    int     s;
    exp_t   e;
    len = r * q;
    h.push_back(1);
    for (int st = 0; st < n; st++) begin
      t.delete();
      for (int i = 0; i < h.size() + len - 1; i++) t.push_back(0);
      for (int i = 0; i < h.size(); i++)
        for (int j = 0; j < len; j++) t[i+j] += h[i];
      h = t;
    end
    acc = 0;
    for (int k = 0; k < h.size() && k < hist.size(); k++)
      acc += h[k] * longint'(hist[hist.size() - 1 - k]);
    s = n * $clog2(len);
    if (s > 0) acc = (acc + (longint'(1) <<< (s - 1))) >>> s;
    e.ovf = 1'b0;
    e.udf = 1'b0;
    if (acc > 32767) begin
      acc = 32767;
      e.ovf = 1'b1;
    end else if (acc < -32768) begin
      acc = -32768;
      e.udf = 1'b1;
    end
    e.val = int'(acc);
    e.due = due;
    return e;
  endfunction

  task automatic check_inst(int i, logic vo, logic signed [DW-1:0] co, logic ov, logic un);
    exp_t e;
    if (ov === 1'b1 || un === 1'b1) nflags++;
    if (vo === 1'b1) begin
      nstrobe[i]++;
      last_out[i] = co;
      checks++;
      if (exp_q[i].size() == 0) begin
        errors++;
        $display("FAIL strobe[%0d] cyc=%0d: got unexpected strobe out=%0d, required no strobe", i, cyc, co);
      end else begin
        e = exp_q[i].pop_front();
        if (e.due != cyc || co !== DW'(e.val) || ov !== e.ovf || un !== e.udf) begin
          errors++;
          $display("FAIL strobe[%0d] cyc=%0d: got out=%0d ovf=%b udf=%b, required out=%0d ovf=%b udf=%b due=%0d",
                   i, cyc, co, ov, un, e.val, e.ovf, e.udf, e.due);
        end
        hold[i] = e.val;
      end
    end else begin
      checks++;
      if (vo !== 1'b0 || co !== DW'(hold[i]) || ov !== 1'b0 || un !== 1'b0) begin
        errors++;
        $display("FAIL idle[%0d] cyc=%0d: got vo=%b out=%0d ovf=%b udf=%b, required vo=0 out=%0d ovf=0 udf=0",
                 i, cyc, vo, co, ov, un, hold[i]);
      end
      if (exp_q[i].size() > 0) begin
        checks++;
        if (exp_q[i][0].due <= cyc) begin
          errors++;
          $display("FAIL missing[%0d] cyc=%0d: got no strobe, required out=%0d at cyc %0d",
                   i, cyc, exp_q[i][0].val, exp_q[i][0].due);
          void'(exp_q[i].pop_front());
        end
      end
    end
  endtask

  // One clock: update the model with the inputs the edge samples, then check
  // both filters #1 after the edge.
  task automatic tick();
    bit do_rst;
    bit take;
    int r;
    int smp;
    do_rst = rst;
    take   = valid_in && !rst;
    r      = reff(dec_factor);
    smp    = cic_in;
    @(posedge clk);
    #1;
    cyc++;
    if (do_rst) begin
      hist.delete();
      cnt = 0;
      exp_q[0].delete();
      exp_q[1].delete();
      hold = '{0, 0};
    end else if (take) begin
      hist.push_back(smp);
      if (hist.size() > 256) void'(hist.pop_front());
      if (cnt == r - 1) begin
        cnt = 0;
        exp_q[0].push_back(model(r, NA, QA, cyc + 2 * NA));
        exp_q[1].push_back(model(r, NB, QB, cyc + 2 * NB));
      end else begin
        cnt++;
      end
    end
    check_inst(0, vo_a, out_a, ov_a, un_a);
    check_inst(1, vo_b, out_b, ov_b, un_b);
  endtask

  task automatic push(int v);
    valid_in = 1'b1;
    cic_in   = DW'(v);
    tick();
  endtask

  task automatic idle(int n);
    valid_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset(logic [4:0] d);
    dec_factor = d;
    valid_in   = 1'b0;
    cic_in     = '0;
    rst        = 1'b1;
    tick();
    rst        = 1'b0;
    nstrobe    = '{0, 0};
  endtask

  task automatic expect_count(string nm, int i, int req);
    checks++;
    if (nstrobe[i] != req) begin
      errors++;
      $display("FAIL %s: got %0d strobes, required %0d", nm, nstrobe[i], req);
    end
  endtask

  task automatic expect_zero_outputs(string nm);
    checks++;
    if (out_a !== '0 || vo_a !== 1'b0 || ov_a !== 1'b0 || un_a !== 1'b0 ||
        out_b !== '0 || vo_b !== 1'b0 || ov_b !== 1'b0 || un_b !== 1'b0) begin
      errors++;
      $display("FAIL %s: got a=%0d/%b%b%b b=%0d/%b%b%b, required all zero",
               nm, out_a, vo_a, ov_a, un_a, out_b, vo_b, ov_b, un_b);
    end
  endtask

  task automatic expect_last(string nm, int req);
    checks++;
    if (last_out[0] != req) begin
      errors++;
      $display("FAIL %s: got last out=%0d, required %0d", nm, last_out[0], req);
    end
  endtask

  vec_t       vecs[14];
  logic [4:0] legal_tbl[5];

  initial begin
    vecs[0]  = '{5'd2,  2, 1,      2,      2};
    vecs[1]  = '{5'd2,  2, -1,     -2,     -1};
    vecs[2]  = '{5'd1,  1, 4660,   0,      4660};
    vecs[3]  = '{5'd4,  4, 16384,  16384,  16384};
    vecs[4]  = '{5'd16, 16, -32768, -32768, -32768};
    vecs[5]  = '{5'd16, 16, 32767,  32767,  32767};
    vecs[6]  = '{5'd8,  8, 3,      0,      0};
    vecs[7]  = '{5'd8,  8, 4,      0,      1};
    vecs[8]  = '{5'd8,  8, -4,     0,      0};
    vecs[9]  = '{5'd8,  8, -5,     0,      -1};
    vecs[10] = '{5'd3,  1, -7,     0,      -7};
    vecs[11] = '{5'd0,  1, 100,    0,      100};
    vecs[12] = '{5'd20, 1, -32768, 0,      -32768};
    vecs[13] = '{5'd4,  4, 7,      0,      2};
    legal_tbl = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16};

    rst        = 1'b1;
    valid_in   = 1'b0;
    dec_factor = 5'd1;
    cic_in     = '0;
    tick();
    expect_zero_outputs("reset_state");
    rst = 1'b0;

    // R=1 ramp across the full input range: output follows input 3 cycles later.
    do_reset(5'd1);
    for (int v = -32768; v <= 32767; v += 257) push(v);
    idle(DRAIN);
    expect_count("ramp_count_a", 0, 256);
    expect_count("ramp_count_b", 1, 256);
    expect_last("ramp_last", 32767);

    // R=4, constant +0.5, 32000 inputs.
    do_reset(5'd4);
    repeat (32000) push(16'h4000);
    idle(DRAIN);
    expect_count("r4_count_a", 0, 8000);
    expect_count("r4_count_b", 1, 8000);
    expect_last("r4_last", 16384);

    // R=16, full-scale negative then full-scale positive: no saturation flags.
    do_reset(5'd16);
    nflags = 0;
    repeat (64) push(-32768);
    repeat (64) push(32767);
    idle(DRAIN);
    checks++;
    if (nflags != 0) begin
      errors++;
      $display("FAIL r16_flags: got %0d flagged cycles, required 0", nflags);
    end
    expect_last("r16_last", 32767);
    expect_count("r16_count_a", 0, 8);

    // R=8, alternating +/-0.25: every output zero.
    do_reset(5'd8);
    for (int k = 0; k < 64; k++) push((k % 2) ? -8192 : 8192);
    idle(DRAIN);
    expect_count("alt_count_a", 0, 8);
    expect_last("alt_last", 0);

    // Vector table: one group per record, one strobe with a hand-computed value.
    for (int v = 0; v < 14; v++) begin
      do_reset(vecs[v].dec);
      for (int k = 0; k < vecs[v].n_in; k++) push(k == 0 ? vecs[v].first : vecs[v].rest);
      idle(DRAIN);
      checks++;
      if (nstrobe[0] != 1 || last_out[0] != vecs[v].exp_a) begin
        errors++;
        $display("FAIL vec[%0d] dec=%0d: got strobes=%0d out=%0d, required strobes=1 out=%0d",
                 v, vecs[v].dec, nstrobe[0], last_out[0], vecs[v].exp_a);
      end
    end

    // Reset in the middle of a group discards the partial group.
    do_reset(5'd8);
    repeat (5) push(28672);
    idle(2);
    expect_count("mid_pre_reset", 0, 0);
    rst = 1'b1;
    tick();
    expect_zero_outputs("mid_during_reset");
    rst = 1'b0;
    tick();
    expect_zero_outputs("mid_after_reset");
    repeat (8) push(4096);
    idle(DRAIN);
    expect_count("mid_count_a", 0, 1);
    expect_last("mid_last", 4096);

    // Random samples and random gaps, including illegal decimation codes.
    for (int t = 0; t < 12; t++) begin
      logic [4:0] d;
      int         m;
      int         r;
      d = (t < 8) ? legal_tbl[t % 5] : 5'($urandom_range(0, 31));
      do_reset(d);
      m = 150 + int'($urandom_range(0, 150));
      for (int k = 0; k < m; k++) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        case ($urandom_range(0, 7))
          0:       push(32767);
          1:       push(-32768);
          default: push(int'($signed(16'($urandom))));
        endcase
      end
      idle(DRAIN);
      r = reff(d);
      expect_count("rand_count_a", 0, m / r);
      expect_count("rand_count_b", 1, m / r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
